// File: rtl/apvm_delay_meter.sv
// apvm_delay_meter
// Checker/monitor that sits beside a delay element on the same clock. Every
// enabled transition on the element input is timestamped into a small
// in-flight FIFO. The next transition on the element output retires the
// oldest entry and yields one delay measurement. Running min/max/count
// statistics and protocol error pulses are kept alongside the measurements.
// All timestamp arithmetic is modulo 2^TS_W.

module apvm_delay_meter #(
    parameter int TS_W      = 16,
    parameter int DEPTH     = 8,
    parameter int MAX_DELAY = 1000,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_sig,
    input  logic                   out_sig,
    input  logic                   clr_stats,
    output logic                   meas_valid,
    output logic [TS_W-1:0]        meas_delay,
    output logic                   meas_pol,
    output logic                   err_overflow,
    output logic                   err_unmatched,
    output logic                   err_pol,
    output logic                   err_timeout,
    output logic [$clog2(DEPTH):0] pending,
    output logic [TS_W-1:0]        min_delay,
    output logic [TS_W-1:0]        max_delay,
    output logic [CNT_W-1:0]       meas_count
);

    // ------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ZERO  = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [TS_W-1:0]  TS_ZERO   = {TS_W{1'b0}};
    localparam logic [TS_W-1:0]  TS_ONE    = TS_W'(1);
    localparam logic [TS_W-1:0]  TS_ONES   = {TS_W{1'b1}};
    localparam logic [TS_W-1:0]  MAX_AGE   = TS_W'(MAX_DELAY);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Elapsed cycles between two timestamps; the counter wraps freely, so
    // a plain modular subtraction gives the right answer across the wrap.
    function automatic logic [TS_W-1:0] ts_diff(
        input logic [TS_W-1:0] now_ts,
        input logic [TS_W-1:0] then_ts
    );
        return now_ts - then_ts;
    endfunction

    // Increment that sticks at all-ones instead of rolling over.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             r_primed;
    logic             r_in_q;
    logic             r_out_q;
    logic [TS_W-1:0]  r_ts;

    logic [TS_W-1:0]  r_fifo_ts  [DEPTH];
    logic             r_fifo_pol [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OCC_W-1:0] r_count;

    logic             r_meas_valid;
    logic [TS_W-1:0]  r_meas_delay;
    logic             r_meas_pol;
    logic             r_err_overflow;
    logic             r_err_unmatched;
    logic             r_err_pol;
    logic             r_err_timeout;

    logic [TS_W-1:0]  r_min;
    logic [TS_W-1:0]  r_max;
    logic [CNT_W-1:0] r_cnt;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic             w_in_edge;
    logic             w_out_edge;
    logic             w_empty;
    logic             w_full;
    logic [TS_W-1:0]  w_head_ts;
    logic             w_head_pol;
    logic [TS_W-1:0]  w_age;
    logic             w_pop_meas;
    logic             w_pop_to;
    logic             w_pop;
    logic             w_unmatched;
    logic             w_push_req;
    logic             w_push;
    logic             w_overflow;
    logic [OCC_W-1:0] w_count_nxt;
    logic [TS_W-1:0]  w_min_base;
    logic [TS_W-1:0]  w_max_base;
    logic [CNT_W-1:0] w_cnt_base;
    logic [TS_W-1:0]  w_min_nxt;
    logic [TS_W-1:0]  w_max_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Edge detection; suppressed until the history flops hold real pin values.
    always_comb begin
        w_in_edge  = 1'b0;
        w_out_edge = 1'b0;
        if (r_primed) begin
            w_in_edge  = in_sig ^ r_in_q;
            w_out_edge = out_sig ^ r_out_q;
        end else begin
            w_in_edge  = 1'b0;
            w_out_edge = 1'b0;
        end
    end

    // Head inspection and pop/push arbitration for this cycle.
    always_comb begin
        w_empty     = (r_count == OCC_ZERO);
        w_full      = (r_count == OCC_FULL);
        w_head_ts   = r_fifo_ts[r_rd_ptr];
        w_head_pol  = r_fifo_pol[r_rd_ptr];
        w_age       = ts_diff(r_ts, w_head_ts);

        // An output edge always wins the single pop slot over an age-out.
        w_pop_meas  = w_out_edge & ~w_empty;
        w_unmatched = w_out_edge & w_empty;
        w_pop_to    = ~w_out_edge & ~w_empty & (w_age > MAX_AGE);
        w_pop       = w_pop_meas | w_pop_to;

        // A full FIFO still takes the new edge if a slot frees up this cycle.
        w_push_req  = w_in_edge & en;
        w_push      = w_push_req & (~w_full | w_pop);
        w_overflow  = w_push_req & w_full & ~w_pop;
    end

    // Occupancy bookkeeping.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + OCC_ONE;
            2'b01:   w_count_nxt = r_count - OCC_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Statistics: a clear is applied first, then the measurement that is
    // currently being presented on the outputs.
    always_comb begin
        w_min_base = r_min;
        w_max_base = r_max;
        w_cnt_base = r_cnt;
        w_min_nxt  = r_min;
        w_max_nxt  = r_max;
        w_cnt_nxt  = r_cnt;
        if (clr_stats) begin
            w_min_base = TS_ONES;
            w_max_base = TS_ZERO;
            w_cnt_base = CNT_ZERO;
        end else begin
            w_min_base = r_min;
            w_max_base = r_max;
            w_cnt_base = r_cnt;
        end
        if (r_meas_valid) begin
            w_min_nxt = (r_meas_delay < w_min_base) ? r_meas_delay : w_min_base;
            w_max_nxt = (r_meas_delay > w_max_base) ? r_meas_delay : w_max_base;
            w_cnt_nxt = sat_inc(w_cnt_base);
        end else begin
            w_min_nxt = w_min_base;
            w_max_nxt = w_max_base;
            w_cnt_nxt = w_cnt_base;
        end
    end

    // Timestamp counter and pin history; first cycle after reset only primes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_primed <= 1'b0;
            r_in_q   <= 1'b0;
            r_out_q  <= 1'b0;
            r_ts     <= TS_ZERO;
        end else begin
            r_primed <= 1'b1;
            r_in_q   <= in_sig;
            r_out_q  <= out_sig;
            r_ts     <= r_ts + TS_ONE;
        end
    end

    // FIFO storage: each entry holds the push timestamp and the new input level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_ts[i]  <= TS_ZERO;
                r_fifo_pol[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_fifo_ts[r_wr_ptr]  <= r_ts;
            r_fifo_pol[r_wr_ptr] <= in_sig;
        end
    end

    // FIFO pointers and occupancy; reset discards anything still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= OCC_ZERO;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
        end
    end

    // Measurement and error pulses, registered one cycle after the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meas_valid    <= 1'b0;
            r_meas_delay    <= TS_ZERO;
            r_meas_pol      <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_err_unmatched <= 1'b0;
            r_err_pol       <= 1'b0;
            r_err_timeout   <= 1'b0;
        end else begin
            r_meas_valid    <= w_pop_meas;
            r_err_overflow  <= w_overflow;
            r_err_unmatched <= w_unmatched;
            r_err_pol       <= w_pop_meas & (w_head_pol ^ out_sig);
            r_err_timeout   <= w_pop_to;
            if (w_pop_meas) begin
                r_meas_delay <= w_age;
                r_meas_pol   <= out_sig;
            end
        end
    end

    // Running statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_min <= TS_ONES;
            r_max <= TS_ZERO;
            r_cnt <= CNT_ZERO;
        end else begin
            r_min <= w_min_nxt;
            r_max <= w_max_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign meas_valid    = r_meas_valid;
    assign meas_delay    = r_meas_delay;
    assign meas_pol      = r_meas_pol;
    assign err_overflow  = r_err_overflow;
    assign err_unmatched = r_err_unmatched;
    assign err_pol       = r_err_pol;
    assign err_timeout   = r_err_timeout;
    assign pending       = r_count;
    assign min_delay     = r_min;
    assign max_delay     = r_max;
    assign meas_count    = r_cnt;

endmodule

// File: tb/tb_apvm_delay_meter.sv
// Testbench for apvm_delay_meter: an event-level reference model (queue of
// timestamped input edges) produces expected pulses into a scoreboard queue;
// an independent monitor pops and compares whenever the DUT pulses.

module tb_apvm_delay_meter;

    localparam int TS_W      = 16;
    localparam int DEPTH     = 8;
    localparam int MAX_DELAY = 1000;
    localparam int CNT_W     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        in_sig = 1'b0;
    logic        out_sig = 1'b0;
    logic        clr_stats = 1'b0;
    logic        meas_valid;
    logic [15:0] meas_delay;
    logic        meas_pol;
    logic        err_overflow;
    logic        err_unmatched;
    logic        err_pol;
    logic        err_timeout;
    logic [3:0]  pending;
    logic [15:0] min_delay;
    logic [15:0] max_delay;
    logic [15:0] meas_count;

    apvm_delay_meter #(
        .TS_W(TS_W), .DEPTH(DEPTH), .MAX_DELAY(MAX_DELAY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in_sig(in_sig), .out_sig(out_sig),
        .clr_stats(clr_stats), .meas_valid(meas_valid), .meas_delay(meas_delay),
        .meas_pol(meas_pol), .err_overflow(err_overflow), .err_unmatched(err_unmatched),
        .err_pol(err_pol), .err_timeout(err_timeout), .pending(pending),
        .min_delay(min_delay), .max_delay(max_delay), .meas_count(meas_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [15:0] ts; logic pol; } ent_t;
    typedef struct {
        int cyc; logic v; logic [15:0] d; logic p; logic ep; logic ov; logic um; logic to;
    } ev_t;

    ent_t        fifo_m[$];
    ev_t         evq[$];
    logic [15:0] m_ts = 16'd0;
    bit          m_primed = 1'b0;
    logic        m_in_q = 1'b0;
    logic        m_out_q = 1'b0;
    logic [15:0] m_min = 16'hFFFF;
    logic [15:0] m_max = 16'd0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_prev_v = 1'b0;
    logic [15:0] m_prev_d = 16'd0;
    int          m_pending = 0;

    // Model: one step per clock edge, working on whole edge events.
    always @(posedge clk) begin : model
        ev_t e;
        ent_t h;
        logic [15:0] age;
        logic in_e;
        logic out_e;
        cyc = cyc + 1;
        e.cyc = cyc; e.v = 1'b0; e.d = 16'd0; e.p = 1'b0; e.ep = 1'b0;
        e.ov = 1'b0; e.um = 1'b0; e.to = 1'b0;
        if (rst) begin
            fifo_m.delete();
            m_ts = 16'd0; m_primed = 1'b0;
            m_min = 16'hFFFF; m_max = 16'd0; m_cnt = 16'd0;
            m_prev_v = 1'b0;
        end else begin
            if (clr_stats) begin
                m_min = 16'hFFFF; m_max = 16'd0; m_cnt = 16'd0;
            end
            if (m_prev_v) begin
                if (m_prev_d < m_min) m_min = m_prev_d;
                if (m_prev_d > m_max) m_max = m_prev_d;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            if (m_primed) begin
                in_e  = (in_sig !== m_in_q);
                out_e = (out_sig !== m_out_q);
                if (out_e) begin
                    if (fifo_m.size() > 0) begin
                        h = fifo_m.pop_front();
                        e.v = 1'b1; e.d = m_ts - h.ts; e.p = out_sig; e.ep = h.pol ^ out_sig;
                    end else begin
                        e.um = 1'b1;
                    end
                end else if (fifo_m.size() > 0) begin
                    age = m_ts - fifo_m[0].ts;
                    if (age > 16'(MAX_DELAY)) begin
                        h = fifo_m.pop_front();
                        e.to = 1'b1;
                    end
                end
                if (in_e && en) begin
                    if (fifo_m.size() < DEPTH) fifo_m.push_back('{ts: m_ts, pol: in_sig});
                    else e.ov = 1'b1;
                end
            end
            m_primed = 1'b1;
            m_in_q = in_sig;
            m_out_q = out_sig;
            m_prev_v = e.v;
            m_prev_d = e.d;
            if (e.v || e.um || e.to || e.ov) evq.push_back(e);
            m_ts = m_ts + 16'd1;
        end
        m_pending = fifo_m.size();
    end

    // ---------------- monitor ----------------
    int n_meas = 0, n_ovf = 0, n_um = 0, n_to = 0, n_ep = 0, pk = 0;
    logic [15:0] last_d = 16'd0;
    logic last_ep = 1'b0, last_p = 1'b0;

    // Monitor: pops the scoreboard on any DUT pulse or overdue expectation.
    always @(negedge clk) begin : monitor
        ev_t e;
        bit any;
        if (mon_on) begin
            any = meas_valid | err_overflow | err_unmatched | err_timeout | err_pol;
            n_meas += int'(meas_valid); n_ovf += int'(err_overflow);
            n_um += int'(err_unmatched); n_to += int'(err_timeout); n_ep += int'(err_pol);
            if (int'(pending) > pk) pk = int'(pending);
            if (meas_valid) begin last_d = meas_delay; last_ep = err_pol; last_p = meas_pol; end
            if (any || (evq.size() > 0 && evq[0].cyc <= cyc)) begin
                if (evq.size() == 0) begin
                    chk("unexpected_pulse",
                        {59'd0, meas_valid, err_overflow, err_unmatched, err_timeout, err_pol}, 64'd0);
                end else begin
                    e = evq.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("meas_valid", meas_valid, e.v);
                    if (e.v) begin
                        chk("meas_delay", meas_delay, e.d);
                        chk("meas_pol", meas_pol, e.p);
                    end
                    chk("err_pol", err_pol, e.ep);
                    chk("err_overflow", err_overflow, e.ov);
                    chk("err_unmatched", err_unmatched, e.um);
                    chk("err_timeout", err_timeout, e.to);
                end
            end
            chk("pending", pending, m_pending);
            chk("min_delay", min_delay, m_min);
            chk("max_delay", max_delay, m_max);
            chk("meas_count", meas_count, m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] hist = 64'd0;
    bit elem_on = 1'b0;
    int elem_dly = 10;

    task automatic drive(input logic iv, input logic ov);
        @(negedge clk);
        in_sig = iv;
        hist = {hist[62:0], iv};
        out_sig = elem_on ? hist[elem_dly] : ov;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(in_sig, out_sig);
    endtask

    task automatic do_reset(input logic iv, input logic ov);
        @(negedge clk);
        rst = 1'b1; clr_stats = 1'b0;
        in_sig = iv; out_sig = ov; hist = {64{iv}};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_on = 1'b1;
    endtask

    int s_meas, s_ovf, s_um, s_to, s_ep, s_all;

    task automatic snap();
        s_meas = n_meas; s_ovf = n_ovf; s_um = n_um; s_to = n_to; s_ep = n_ep;
        s_all = n_meas + n_ovf + n_um + n_to + n_ep;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // 1: element delay 10, four edges at ts 12..15
        elem_on = 1'b1; elem_dly = 10; en = 1'b1;
        do_reset(1'b0, 1'b0);
        chk("reset_pending", pending, 0);
        chk("reset_min", min_delay, 16'hFFFF);
        chk("reset_count", meas_count, 0);
        snap(); pk = 0;
        idle(11);
        drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0);
        idle(20);
        chk("t1_meas_n", n_meas - s_meas, 4);
        chk("t1_peak", pk, 4);
        chk("t1_min", min_delay, 10);
        chk("t1_max", max_delay, 10);
        chk("t1_count", meas_count, 4);
        chk("t1_errpol_n", n_ep - s_ep, 0);

        // 2: en=0 ignores input edges
        elem_on = 1'b0; en = 1'b0;
        do_reset(1'b0, 1'b0);
        snap();
        drive(1'b1, 1'b0); drive(1'b0, 1'b0);
        idle(5);
        chk("t2_pending", pending, 0);
        chk("t2_pulses", n_meas + n_ovf + n_um + n_to + n_ep - s_all, 0);

        // 3: overflow then timeouts
        en = 1'b1;
        do_reset(1'b0, 1'b0);
        snap();
        for (int i = 0; i < 9; i++) drive(~in_sig, 1'b0);
        idle(2);
        chk("t3_pending_full", pending, 8);
        chk("t3_overflow_n", n_ovf - s_ovf, 1);
        idle(MAX_DELAY + 10);
        chk("t3_timeout_n", n_to - s_to, 8);
        chk("t3_pending_empty", pending, 0);

        // 4: unmatched output edges
        do_reset(1'b0, 1'b0);
        snap();
        drive(1'b0, 1'b1); idle(2);
        drive(1'b1, 1'b0); idle(2);
        chk("t4_unmatched_n", n_um - s_um, 2);
        chk("t4_pending", pending, 1);

        // 5: polarity error across timestamp wrap
        do_reset(1'b0, 1'b1);
        snap();
        do drive(1'b0, 1'b1); while (m_ts != 16'hFFFC);
        drive(1'b1, 1'b1);
        idle(4);
        drive(1'b1, 1'b0);
        idle(2);
        chk("t5_meas_n", n_meas - s_meas, 1);
        chk("t5_delay", last_d, 5);
        chk("t5_errpol", last_ep, 1);
        chk("t5_pol", last_p, 0);

        // 6a: reset with three pending entries
        do_reset(1'b0, 1'b0);
        drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
        idle(1);
        chk("t6_pending_pre", pending, 3);
        snap();
        do_reset(in_sig, out_sig);
        drive(in_sig, out_sig);
        chk("t6_pending_post", pending, 0);
        chk("t6_min_post", min_delay, 16'hFFFF);
        chk("t6_pulses", n_meas + n_ovf + n_um + n_to + n_ep - s_all, 0);

        // 6b: clr_stats coincident with a delay-7 measurement
        do_reset(1'b0, 1'b0);
        drive(1'b1, 1'b0); idle(2); drive(1'b1, 1'b1); idle(3);
        drive(1'b0, 1'b1); idle(6); drive(1'b0, 1'b0);
        drive(1'b0, 1'b0); clr_stats = 1'b1;
        drive(1'b0, 1'b0); clr_stats = 1'b0;
        idle(2);
        chk("t6_min", min_delay, 7);
        chk("t6_max", max_delay, 7);
        chk("t6_count", meas_count, 1);

        // random mix: element / manual output, random en and clears
        do_reset(1'b0, 1'b0);
        for (int s = 0; s < 12; s++) begin
            elem_on = ($urandom_range(0, 3) != 0);
            elem_dly = $urandom_range(1, 24);
            for (int k = 0; k < 250; k++) begin
                en = ($urandom_range(0, 4) != 0);
                clr_stats = ($urandom_range(0, 40) == 0);
                drive(in_sig ^ ($urandom_range(0, 2) == 0), out_sig ^ ($urandom_range(0, 5) == 0));
            end
        end
        clr_stats = 1'b0; elem_on = 1'b0;
        idle(5);
        chk("scoreboard_drained", evq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
